// File: rtl/golomb_pkg.sv
// rtl/golomb_pkg.sv - shared widths, helpers and the Golomb-Rice encode function
//
// Purpose: single source of the encoder geometry (value width, k width, codeword
// width, FIFO depth) plus the combinational encode used by the top level.
// Ports: none (package).
package golomb_pkg;

  localparam int DATA_WIDTH          = 19;
  localparam int MAX_PARAM_VALUE     = 19;
  localparam int MAX_PARAM_VALUE_LOG = 5;
  localparam int OUTPUT_WIDTH        = 2 * DATA_WIDTH + 1;
  localparam int SLACK_LOG           = 4;
  localparam int MAX_1_OUT_LOG       = 5;

  // Quotients at or above this threshold are sent as an escape code.
  function automatic int esc_threshold();
    return OUTPUT_WIDTH - DATA_WIDTH;
  endfunction

  // Width needed to express a length of 0..OUTPUT_WIDTH.
  function automatic int len_width();
    return $clog2(OUTPUT_WIDTH + 1);
  endfunction

  localparam int ESC   = esc_threshold();
  localparam int LEN_W = len_width();
  localparam int K_W   = MAX_PARAM_VALUE_LOG;

  typedef struct packed {
    logic [OUTPUT_WIDTH-1:0] code;
    logic [LEN_W-1:0]        length;
  } golomb_code_t;

  // (x, k) -> right-aligned codeword and its bit length.
  function automatic golomb_code_t golomb_encode(input logic [DATA_WIDTH-1:0] x,
                                                 input logic [K_W-1:0]        k);
    logic [DATA_WIDTH-1:0]    q;
    logic [DATA_WIDTH-1:0]    r;
    logic [MAX_1_OUT_LOG-1:0] ones;
    logic [OUTPUT_WIDTH-1:0]  prefix;
    golomb_code_t             res;
    q = x >> k;
    // For k == DATA_WIDTH the shifted one falls off the top, so the mask
    // wraps to all ones, which is exactly the full-width remainder.
    r = x & ((DATA_WIDTH'(1) << k) - DATA_WIDTH'(1));
    if (q < DATA_WIDTH'(ESC)) begin
      ones   = MAX_1_OUT_LOG'(q);
      // Unary run sits above the separator zero at bit k.
      prefix = ((OUTPUT_WIDTH'(1) << ones) - OUTPUT_WIDTH'(1)) << ({1'b0, k} + 6'd1);
      res.code   = prefix | OUTPUT_WIDTH'(r);
      res.length = LEN_W'(ones) + LEN_W'(k) + LEN_W'(1);
    end else begin
      ones   = MAX_1_OUT_LOG'(ESC);
      prefix = ((OUTPUT_WIDTH'(1) << ones) - OUTPUT_WIDTH'(1)) << DATA_WIDTH;
      res.code   = prefix | OUTPUT_WIDTH'(x);
      res.length = LEN_W'(OUTPUT_WIDTH);
    end
    return res;
  endfunction

endpackage

// File: rtl/golomb_coding_if.sv
// rtl/golomb_coding_if.sv - stream bundle for the Golomb-Rice encoder
//
// Purpose: groups the param, value and codeword streams.
// Signals: input_param_* (k stream), input_value_* (x stream),
//          output_* (codeword stream).
// Modports: slave = encoder view, master = source/sink view.
interface golomb_coding_if;
  import golomb_pkg::*;

  logic [K_W-1:0]          input_param_data;
  logic                    input_param_valid;
  logic                    input_param_ready;
  logic                    input_param_last;
  logic [DATA_WIDTH-1:0]   input_value_data;
  logic                    input_value_valid;
  logic                    input_value_ready;
  logic                    input_value_last;
  logic [OUTPUT_WIDTH-1:0] output_code;
  logic [LEN_W-1:0]        output_length;
  logic                    output_last;
  logic                    output_valid;
  logic                    output_ready;

  modport slave (
    input  input_param_data, input_param_valid, input_param_last,
    output input_param_ready,
    input  input_value_data, input_value_valid, input_value_last,
    output input_value_ready,
    output output_code, output_length, output_last, output_valid,
    input  output_ready
  );

  modport master (
    output input_param_data, input_param_valid, input_param_last,
    input  input_param_ready,
    output input_value_data, input_value_valid, input_value_last,
    input  input_value_ready,
    input  output_code, output_length, output_last, output_valid,
    output output_ready
  );

endinterface

// File: rtl/golomb_input_fifo.sv
// rtl/golomb_input_fifo.sv - stream FIFO carrying data plus last
//
// Purpose: 2**DEPTH_LOG entry buffer in front of each encoder input.
// Ports: clk, rst (async, active-low); in_tdata/in_tlast/in_tvalid/in_tready
//        write side; out_tdata/out_tlast/out_tvalid read side, out_tready pops.
module golomb_input_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tlast,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tlast,
  output logic             out_tvalid,
  input  logic             out_tready
);

  localparam logic [DEPTH_LOG:0] PTR_ONE = 1;

  logic [WIDTH:0]     mem [2**DEPTH_LOG];
  logic [DEPTH_LOG:0] wr_ptr;
  logic [DEPTH_LOG:0] rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]) &&
                 (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]);

  // Ready is held low while reset is asserted.
  assign in_tready  = rst && !full;
  assign out_tvalid = !empty;
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tready && !empty;

  assign {out_tlast, out_tdata} = mem[rd_ptr[DEPTH_LOG-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG-1:0]] <= {in_tlast, in_tdata};
  end

endmodule

// File: rtl/golomb_coding.sv
// rtl/golomb_coding.sv - streaming Golomb-Rice encoder top level
//
// Purpose: buffers the value and k streams, joins them in order, encodes
// each pair and holds the codeword in an output register.
// Ports: clk; rst (async, active-low); bus (golomb_coding_if.slave) with the
//        param/value input streams and the codeword output stream.
// Option: GOLOMB_PARAM_CLAMP_EN clamps k to MAX_PARAM_VALUE.
module golomb_coding
  import golomb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  golomb_coding_if.slave bus
);

  logic [K_W-1:0]          p_data;
  logic                    p_last;
  logic                    p_valid;
  logic [DATA_WIDTH-1:0]   v_data;
  logic                    v_last;
  logic                    v_valid;
  logic                    join_fire;
  logic [K_W-1:0]          k_eff;
  golomb_code_t            enc;

  logic [OUTPUT_WIDTH-1:0] out_code;
  logic [LEN_W-1:0]        out_length;
  logic                    out_last;
  logic                    out_valid;

  golomb_input_fifo #(.WIDTH(K_W), .DEPTH_LOG(SLACK_LOG)) u_param_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_tdata   (bus.input_param_data),
    .in_tlast   (bus.input_param_last),
    .in_tvalid  (bus.input_param_valid),
    .in_tready  (bus.input_param_ready),
    .out_tdata  (p_data),
    .out_tlast  (p_last),
    .out_tvalid (p_valid),
    .out_tready (join_fire)
  );

  golomb_input_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_LOG(SLACK_LOG)) u_value_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_tdata   (bus.input_value_data),
    .in_tlast   (bus.input_value_last),
    .in_tvalid  (bus.input_value_valid),
    .in_tready  (bus.input_value_ready),
    .out_tdata  (v_data),
    .out_tlast  (v_last),
    .out_tvalid (v_valid),
    .out_tready (join_fire)
  );

  // Both heads leave together, so the Nth value always meets the Nth k.
  assign join_fire = p_valid && v_valid && (!out_valid || bus.output_ready);

`ifdef GOLOMB_PARAM_CLAMP_EN
  assign k_eff = (p_data > K_W'(MAX_PARAM_VALUE)) ? K_W'(MAX_PARAM_VALUE) : p_data;

  always @(posedge clk) begin
    if (rst && join_fire) begin
      assert (p_data <= K_W'(MAX_PARAM_VALUE))
        else $warning("golomb_coding: k=%0d clamped to %0d", p_data, MAX_PARAM_VALUE);
    end
  end
`else
  assign k_eff = p_data;
`endif

  always_comb begin
    enc = golomb_encode(v_data, k_eff);
  end

  // Load on join (also when the current word is being read); otherwise a
  // read empties the register and a stall holds it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_code   <= '0;
      out_length <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else if (join_fire) begin
      out_code   <= enc.code;
      out_length <= enc.length;
      out_last   <= v_last | p_last;
      out_valid  <= 1'b1;
    end else if (bus.output_ready) begin
      out_valid  <= 1'b0;
    end
  end

  assign bus.output_code   = out_code;
  assign bus.output_length = out_length;
  assign bus.output_last   = out_last;
  assign bus.output_valid  = out_valid;

endmodule

// File: tb/tb_golomb_coding.sv
// tb/tb_golomb_coding.sv - scoreboard bench for golomb_coding
module tb_golomb_coding;
  import golomb_pkg::*;

  typedef struct { logic [DATA_WIDTH-1:0] d; logic l; } val_t;
  typedef struct { logic [K_W-1:0] d; logic l; } par_t;
  typedef struct { logic [63:0] code; int len; logic last; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  golomb_coding_if bus ();

  golomb_coding dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  val_t val_src[$];
  par_t par_src[$];
  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   v_accepted = 0;
  int   p_accepted = 0;
  bit   val_en = 1'b1;
  bit   par_en = 1'b1;
  int   ready_mode = 0;  // 0 hold low, 1 hold high, 2 random

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bench reference: appends bits one at a time, MSB of the codeword first.
  function automatic void ref_encode(input int unsigned x, input int unsigned k,
                                     output logic [63:0] code, output int len);
    int unsigned q;
    q = x >> k;
    code = '0;
    len = 0;
    if (q < 20) begin
      for (int i = 0; i < int'(q); i++) begin code = {code[62:0], 1'b1}; len++; end
      code = {code[62:0], 1'b0}; len++;
      for (int i = int'(k) - 1; i >= 0; i--) begin
        code = {code[62:0], 1'(((x >> i) & 1))}; len++;
      end
    end else begin
      for (int i = 0; i < 20; i++) begin code = {code[62:0], 1'b1}; len++; end
      for (int i = 18; i >= 0; i--) begin
        code = {code[62:0], 1'(((x >> i) & 1))}; len++;
      end
    end
  endfunction

  task automatic push_pair(input int unsigned x, input int unsigned k,
                           input logic vl, input logic pl,
                           input logic [63:0] code, input int len);
    val_t v; par_t p; exp_t e;
    v.d = DATA_WIDTH'(x); v.l = vl;
    p.d = K_W'(k);        p.l = pl;
    e.code = code; e.len = len; e.last = vl | pl;
    val_src.push_back(v);
    par_src.push_back(p);
    exp_q.push_back(e);
  endtask

  task automatic add_pair(input int unsigned x, input int unsigned k,
                          input logic vl, input logic pl);
    logic [63:0] c; int n;
    ref_encode(x, k, c, n);
    push_pair(x, k, vl, pl, c, n);
  endtask

  task automatic add_random(input int n);
    int unsigned x, k;
    for (int i = 0; i < n; i++) begin
      x = $urandom_range(0, 524287) >> $urandom_range(0, 19);
      k = $urandom_range(0, 19);
      add_pair(x, k, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Value stream driver.
  initial begin : value_drv
    bit fire;
    bus.input_value_valid = 1'b0;
    bus.input_value_data  = '0;
    bus.input_value_last  = 1'b0;
    forever begin
      @(negedge clk);
      fire = bus.input_value_valid && bus.input_value_ready;
      @(posedge clk); #1;
      if (fire && val_src.size() != 0) begin
        void'(val_src.pop_front());
        v_accepted++;
      end
      if (val_en && val_src.size() != 0) begin
        bus.input_value_data  = val_src[0].d;
        bus.input_value_last  = val_src[0].l;
        bus.input_value_valid = 1'b1;
      end else begin
        bus.input_value_valid = 1'b0;
      end
    end
  end

  // Param stream driver.
  initial begin : param_drv
    bit fire;
    bus.input_param_valid = 1'b0;
    bus.input_param_data  = '0;
    bus.input_param_last  = 1'b0;
    forever begin
      @(negedge clk);
      fire = bus.input_param_valid && bus.input_param_ready;
      @(posedge clk); #1;
      if (fire && par_src.size() != 0) begin
        void'(par_src.pop_front());
        p_accepted++;
      end
      if (par_en && par_src.size() != 0) begin
        bus.input_param_data  = par_src[0].d;
        bus.input_param_last  = par_src[0].l;
        bus.input_param_valid = 1'b1;
      end else begin
        bus.input_param_valid = 1'b0;
      end
    end
  end

  // Output ready driver.
  initial begin : ready_drv
    bus.output_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.output_ready = 1'b0;
        1:       bus.output_ready = 1'b1;
        default: bus.output_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.output_valid && bus.output_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("code",   64'(bus.output_code),   e.code);
          check("length", 64'(bus.output_length), 64'(e.len));
          check("last",   64'(bus.output_last),   64'(e.last));
        end
      end
    end
  end

  initial begin : main
    int v0, p0;
    bit have_cap;
    logic [63:0] cap_code, cap_len;

    // Reset state.
    #12;
    check("rst_valid",   64'(bus.output_valid),      64'd0);
    check("rst_code",    64'(bus.output_code),       64'd0);
    check("rst_length",  64'(bus.output_length),     64'd0);
    check("rst_last",    64'(bus.output_last),       64'd0);
    check("rst_p_ready", 64'(bus.input_param_ready), 64'd0);
    check("rst_v_ready", 64'(bus.input_value_ready), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("post_rst_v_ready", 64'(bus.input_value_ready), 64'd1);

    // Directed pairs including boundary and escape codes.
    ready_mode = 1;
    @(posedge clk); #2;
    push_pair(13, 2, 0, 0, 64'd57, 6);
    push_pair(0, 0, 0, 0, 64'd0, 1);
    push_pair(5, 0, 0, 0, 64'h3E, 6);
    push_pair(19, 0, 0, 0, 64'hFFFFE, 20);
    push_pair(524287, 19, 0, 0, 64'h7FFFF, 20);
    push_pair(100, 0, 0, 0, 64'h7FFFF80064, 39);
    push_pair(20, 0, 0, 0, 64'h7FFFF80014, 39);
    wait_drain(200);

    // Last flag on the 4th value only.
    @(posedge clk); #2;
    for (int i = 0; i < 6; i++)
      add_pair($urandom_range(0, 300), $urandom_range(0, 6), (i == 3), 1'b0);
    wait_drain(200);

    // Backpressure: output stalled for 40 cycles.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    v0 = v_accepted; p0 = p_accepted;
    add_random(30);
    have_cap = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.output_valid) begin
        if (!have_cap) begin
          cap_code = 64'(bus.output_code);
          cap_len  = 64'(bus.output_length);
          have_cap = 1'b1;
        end else begin
          check("stall_code", 64'(bus.output_code), cap_code);
        end
      end
    end
    check("stall_valid",   64'(bus.output_valid),      64'd1);
    check("stall_length",  64'(bus.output_length),     cap_len);
    check("stall_v_count", 64'(v_accepted - v0),       64'd17);
    check("stall_p_count", 64'(p_accepted - p0),       64'd17);
    check("stall_v_ready", 64'(bus.input_value_ready), 64'd0);
    check("stall_p_ready", 64'(bus.input_param_ready), 64'd0);
    ready_mode = 2;
    wait_drain(1000);

    // Skewed streams: values arrive well before params.
    ready_mode = 1;
    par_en = 1'b0;
    @(posedge clk); #2;
    add_random(8);
    repeat (10) @(negedge clk);
    check("skew_no_output", 64'(bus.output_valid), 64'd0);
    par_en = 1'b1;
    wait_drain(300);

    // Random traffic with random output ready.
    ready_mode = 2;
    @(posedge clk); #2;
    add_random(40);
    wait_drain(2000);

    // Reset in the middle of a stream.
    @(posedge clk); #2;
    add_random(20);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    val_src.delete();
    par_src.delete();
    exp_q.delete();
    #1;
    check("midrst_valid",   64'(bus.output_valid),      64'd0);
    check("midrst_code",    64'(bus.output_code),       64'd0);
    check("midrst_v_ready", 64'(bus.input_value_ready), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_empty",   64'(bus.output_valid),      64'd0);
    check("postrst_p_ready", 64'(bus.input_param_ready), 64'd1);
    ready_mode = 1;
    @(posedge clk); #2;
    add_pair(13, 2, 0, 0);
    add_random(5);
    wait_drain(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
